pattern_detect_mac: RTL and testbench
=====================================

# pattern_detect_mac

Parametrised, pipelined signed multiply / multiply-accumulate unit with masked pattern detection, the next generation of the team's multiplier pattern detector. Each accepted operand pair yields `a*b` (multiply mode) or a running sum (accumulate mode). The result is compared against a runtime pattern under a bit mask. The block adds a valid handshake, pattern-bar and past-detect flags, auto-reset-on-match accumulation and signed overflow reporting. It sits in the DSP datapath between operand capture and downstream threshold/event logic.

## Interface
- `A_W`, 11, width of operand `a` (signed two's complement)
- `B_W`, 11, width of operand `b` (signed)
- `P_W`, 24, result/accumulator width; must satisfy `P_W >= A_W+B_W`
- `clk` in 1: rising-edge clock
- `rst_n` in 1: asynchronous, active-low reset
- `in_valid` in 1: operand pair valid this cycle
- `a` in A_W: signed multiplicand
- `b` in B_W: signed multiplier
- `mode` in 1: 0 = multiply, 1 = accumulate; sampled with the operands
- `clr_acc` in 1: sampled with the operands; the sample starts a fresh sum and clears `ovf_sticky`
- `autoreset_en` in 1: static config; a match zeroes the accumulator base
- `pattern` in P_W: compare pattern (quasi-static)
- `mask` in P_W: 1 = bit ignored in all compares
- `out_valid` out 1: result and flags valid
- `p` out P_W: result
- `pat_det` out 1: `((p ^ pattern) & ~mask) == 0`
- `patb_det` out 1: `((p ^ ~pattern) & ~mask) == 0`
- `pat_det_past` out 1: `pat_det` of the previous valid output
- `ones_o` out 1: `(p | mask)` is all ones
- `overflow` out 1: signed overflow occurred in this sample's accumulate add
- `ovf_sticky` out 1: OR of `overflow` since the last `clr_acc` or reset

## Operation
- Stage 1 registers `a`, `b`, `mode`, `clr_acc` and the valid bit `v1`.
- Stage 2 forms `m = a*b`, signed, sign-extended to P_W, and registers it with `v2`.
- Stage 3 holds the accumulator `p3`. On `v2`:
  - mode 0: `p3 = m`
  - mode 1: `p3 = base + m`, P_W-bit wrap-around
  - `base = 0` if the sample's `clr_acc`, or if `autoreset_en` and the current `p3` matches the pattern. Otherwise `base = p3`.
  - `clr_acc` has priority; both conditions give the same result.
- Stage 3 signed overflow: the operand signs are equal and the sum sign differs. This is evaluated in mode 1 only; mode 0 never sets overflow.
- Stage 4 computes the compares on `p3` combinationally and registers them with `p`, `overflow` and `out_valid = v3`.
  - `pat_det_past` loads the old `pat_det` on each valid output.
  - `ovf_sticky` is cleared when the sample carrying `clr_acc` reaches stage 4, then ORs in that sample's overflow.
- Bubbles:
  - `in_valid = 0` propagates as invalid. No stage data register changes on an invalid slot.
  - `p3`, `p` and all flags hold their values. `out_valid` is 0.
- Mode may change per sample. A mode-0 sample overwrites `p3`, so a following mode-1 sample accumulates onto that product.
- With `mask` all ones, `pat_det`, `patb_det` and `ones_o` are all 1.

## Timing
- Latency: a sample accepted at edge N has `out_valid = 1` with its result after edge N+3, i.e. four register stages including input capture.
- Throughput is one sample per clock. There is no backpressure: downstream must accept every `out_valid`.
- Back-to-back accumulation needs no stall; `base` uses the `p3` value registered on the previous edge.
- Reset (asynchronous assert, any time, including mid-accumulation): all pipeline valids, `p3`, `p`, `out_valid`, `pat_det`, `patb_det`, `pat_det_past`, `ones_o`, `overflow` and `ovf_sticky` go to 0. In-flight samples are discarded.
- Reset release is synchronous to `clk`. The first sample accepted after release has `base = 0`.
- `pattern`, `mask` and `autoreset_en` changes take effect on the next stage-3/4 evaluation. They are not pipelined with data.

## Test plan
- Mode 0, a=12, b=2, pattern=24, mask=0, single pulse:
  - `out_valid` 3 edges later, p=24, pat_det=1, patb_det=0.
  - Next identical sample gives pat_det_past=1.
- Mode 1, first sample `clr_acc=1`, three back-to-back samples a=5, b=3 -> p = 15, 30, 45 on consecutive cycles. Insert a one-cycle bubble between samples 2 and 3 -> same values, with `out_valid` gapped.
- Mode 1, autoreset_en=1, pattern=30, mask=0, four samples of 5*3 -> p = 15, 30, 15, 30, with pat_det = 0,1,0,1.
- Masking, p=0x0000FF:
  - pattern=0x0000F0 with mask=0x00000F -> pat_det=1.
  - mask=0xFFFF00 -> ones_o=1.
  - a=-1, b=1 (p=0xFFFFFF), mask=0 -> ones_o=1; patb_det=1 with pattern=0.
- Overflow, mode 1, a=1023, b=1023, nine samples:
  - First eight give p up to 8372232 with overflow=0.
  - Ninth wraps negative: overflow=1, ovf_sticky=1.
  - A `clr_acc` sample then clears ovf_sticky.
- Assert `rst_n = 0` mid-accumulation with two samples in flight:
  - All outputs read 0 immediately, asynchronously.
  - No `out_valid` for the discarded samples.
  - A post-release 5*3 accumulate gives p=15.

Source files
------------

// File: rtl/pattern_detect_mac.sv
// Pipelined signed multiply / multiply-accumulate with masked pattern detection,
// pattern-bar / past-detect flags, auto-reset-on-match and signed overflow reporting.
module pattern_detect_mac #(
  parameter int A_W = 11,
  parameter int B_W = 11,
  parameter int P_W = 24
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  input  logic           mode,
  input  logic           clr_acc,
  input  logic           autoreset_en,
  input  logic [P_W-1:0] pattern,
  input  logic [P_W-1:0] mask,
  output logic           out_valid,
  output logic [P_W-1:0] p,
  output logic           pat_det,
  output logic           patb_det,
  output logic           pat_det_past,
  output logic           ones_o,
  output logic           overflow,
  output logic           ovf_sticky
);

  logic           v1_q, v2_q, v3_q;
  logic [A_W-1:0] a_q;
  logic [B_W-1:0] b_q;
  logic           mode1_q, clr1_q, mode2_q, clr2_q, clr3_q;
  logic [P_W-1:0] m_q, m_d;
  logic [P_W-1:0] p3_q, p3_d, base_s, sum_s;
  logic           ovf3_q, ovf_s, match_p3_s;
  logic [P_W-1:0] p_q;
  logic           out_valid_q, pat_q, patb_q, past_q, ones_q, ovf_q, sticky_q;
  logic           pat_s, patb_s, ones_s, sticky_d;
  logic [P_W-1:0] a_ext_s, b_ext_s;

  // Stage 1: operand capture; data registers only load on a valid slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      mode1_q <= 1'b0;
      clr1_q  <= 1'b0;
    end else begin
      v1_q <= in_valid;
      if (in_valid) begin
        a_q     <= a;
        b_q     <= b;
        mode1_q <= mode;
        clr1_q  <= clr_acc;
      end
    end
  end

  // Sign-extend both operands to P_W first so the truncated product is exact
  assign a_ext_s = {{(P_W-A_W){a_q[A_W-1]}}, a_q};
  assign b_ext_s = {{(P_W-B_W){b_q[B_W-1]}}, b_q};
  assign m_d     = a_ext_s * b_ext_s;

  // Stage 2: product register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q    <= 1'b0;
      m_q     <= '0;
      mode2_q <= 1'b0;
      clr2_q  <= 1'b0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        m_q     <= m_d;
        mode2_q <= mode1_q;
        clr2_q  <= clr1_q;
      end
    end
  end

  // Stage 3 next state: base selection, wrap-around add and signed overflow
  always_comb begin
    match_p3_s = (((p3_q ^ pattern) & ~mask) == '0);
    base_s     = p3_q;
    ovf_s      = 1'b0;
    if (clr2_q || (autoreset_en && match_p3_s)) begin
      base_s = '0;
    end else begin
      base_s = p3_q;
    end
    sum_s = base_s + m_q;
    if (mode2_q) begin
      p3_d  = sum_s;
      ovf_s = (base_s[P_W-1] == m_q[P_W-1]) && (sum_s[P_W-1] != base_s[P_W-1]);
    end else begin
      p3_d  = m_q;
      ovf_s = 1'b0;
    end
  end

  // Stage 3: accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_q   <= 1'b0;
      p3_q   <= '0;
      ovf3_q <= 1'b0;
      clr3_q <= 1'b0;
    end else begin
      v3_q <= v2_q;
      if (v2_q) begin
        p3_q   <= p3_d;
        ovf3_q <= ovf_s;
        clr3_q <= clr2_q;
      end
    end
  end

  // Stage 4 compares evaluated on the accumulator with the live pattern/mask
  always_comb begin
    pat_s    = (((p3_q ^ pattern) & ~mask) == '0);
    patb_s   = (((p3_q ^ ~pattern) & ~mask) == '0);
    ones_s   = ((p3_q | mask) == {P_W{1'b1}});
    sticky_d = (clr3_q ? 1'b0 : sticky_q) | ovf3_q;
  end

  // Stage 4: registered result and flags, held across bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      p_q         <= '0;
      pat_q       <= 1'b0;
      patb_q      <= 1'b0;
      past_q      <= 1'b0;
      ones_q      <= 1'b0;
      ovf_q       <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      out_valid_q <= v3_q;
      if (v3_q) begin
        p_q      <= p3_q;
        pat_q    <= pat_s;
        patb_q   <= patb_s;
        past_q   <= pat_q;
        ones_q   <= ones_s;
        ovf_q    <= ovf3_q;
        sticky_q <= sticky_d;
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign p            = p_q;
  assign pat_det      = pat_q;
  assign patb_det     = patb_q;
  assign pat_det_past = past_q;
  assign ones_o       = ones_q;
  assign overflow     = ovf_q;
  assign ovf_sticky   = sticky_q;

endmodule

// File: tb/tb_pattern_detect_mac.sv
// Directed bench for pattern_detect_mac: a behavioural model fills a scoreboard
// at drive time and a monitor pops and compares every out_valid result.
module tb_pattern_detect_mac;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [10:0] a = 11'd0;
  logic [10:0] b = 11'd0;
  logic        mode = 1'b0;
  logic        clr_acc = 1'b0;
  logic        autoreset_en = 1'b0;
  logic [23:0] pattern = 24'd0;
  logic [23:0] mask = 24'd0;
  logic        out_valid;
  logic [23:0] p;
  logic        pat_det, patb_det, pat_det_past, ones_o, overflow, ovf_sticky;

  pattern_detect_mac #(.A_W(11), .B_W(11), .P_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .mode(mode),
    .clr_acc(clr_acc), .autoreset_en(autoreset_en), .pattern(pattern), .mask(mask),
    .out_valid(out_valid), .p(p), .pat_det(pat_det), .patb_det(patb_det),
    .pat_det_past(pat_det_past), .ones_o(ones_o), .overflow(overflow),
    .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] p;
    logic [5:0]  f;
  } exp_t;

  exp_t        sb_q[$];
  int          pass_cnt = 0;
  int          fail_cnt = 0;
  int          total_cnt = 0;
  int          n_push = 0;
  int          n_out = 0;
  logic [23:0] m_acc = 24'd0;
  logic        m_prev_pat = 1'b0;
  logic        m_sticky = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one sample and push the model's expected output
  task automatic drive(input int av, input int bv, input logic md, input logic cl);
    int          prod_i, base_i, sum_i;
    logic        ovf_e, pat_e, patb_e, ones_e;
    logic [23:0] pv;
    exp_t        e;
    @(negedge clk);
    in_valid = 1'b1;
    a = av[10:0];
    b = bv[10:0];
    mode = md;
    clr_acc = cl;
    prod_i = av * bv;
    if (cl || (autoreset_en && (((m_acc ^ pattern) & ~mask) == 24'd0))) base_i = 0;
    else base_i = int'($signed(m_acc));
    if (md) begin
      sum_i = base_i + prod_i;
      ovf_e = (sum_i > 8388607) || (sum_i < -8388608);
    end else begin
      sum_i = prod_i;
      ovf_e = 1'b0;
    end
    pv     = sum_i[23:0];
    m_acc  = pv;
    pat_e  = (((pv ^ pattern) & ~mask) == 24'd0);
    patb_e = (((pv ^ ~pattern) & ~mask) == 24'd0);
    ones_e = ((pv | mask) == 24'hFFFFFF);
    m_sticky = (cl ? 1'b0 : m_sticky) | ovf_e;
    e.p = pv;
    e.f = {pat_e, patb_e, m_prev_pat, ones_e, ovf_e, m_sticky};
    m_prev_pat = pat_e;
    sb_q.push_back(e);
    n_push++;
  endtask

  task automatic bubble();
    @(negedge clk);
    in_valid = 1'b0;
    clr_acc = 1'b0;
  endtask

  task automatic drain();
    repeat (6) bubble();
  endtask

  // Monitor: compare every valid output against the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid) begin
      n_out++;
      if (sb_q.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("p", 32'(p), 32'(e.p));
        check("flags{pat,patb,past,ones,ovf,sticky}",
              32'({pat_det, patb_det, pat_det_past, ones_o, overflow, ovf_sticky}), 32'(e.f));
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'({out_valid, p, pat_det, patb_det, pat_det_past, ones_o,
                              overflow, ovf_sticky}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Multiply with latency check, then identical sample for past detect
    pattern = 24'd24;
    mask = 24'd0;
    drive(12, 2, 1'b0, 1'b0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 check("latency_not_yet", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 check("latency_valid", 32'(out_valid), 32'd1);
    drive(12, 2, 1'b0, 1'b0);
    drain();

    // Back-to-back accumulate, then with a bubble before sample 3
    drive(5, 3, 1'b1, 1'b1);
    drive(5, 3, 1'b1, 1'b0);
    drive(5, 3, 1'b1, 1'b0);
    drain();
    drive(5, 3, 1'b1, 1'b1);
    drive(5, 3, 1'b1, 1'b0);
    bubble();
    drive(5, 3, 1'b1, 1'b0);
    drain();

    // Auto-reset on match
    autoreset_en = 1'b1;
    pattern = 24'd30;
    drive(5, 3, 1'b1, 1'b1);
    repeat (3) drive(5, 3, 1'b1, 1'b0);
    drain();
    autoreset_en = 1'b0;

    // Masking
    pattern = 24'h0000F0;
    mask = 24'h00000F;
    drive(15, 17, 1'b0, 1'b0);
    drain();
    mask = 24'hFFFF00;
    drive(15, 17, 1'b0, 1'b0);
    drain();
    pattern = 24'd0;
    mask = 24'd0;
    drive(-1, 1, 1'b0, 1'b0);
    drain();
    mask = 24'hFFFFFF;
    pattern = 24'h123456;
    drive(7, -9, 1'b0, 1'b0);
    drain();
    mask = 24'd0;
    pattern = 24'd0;

    // Overflow and sticky, then clr_acc clears sticky
    drive(1023, 1023, 1'b1, 1'b1);
    repeat (8) drive(1023, 1023, 1'b1, 1'b0);
    drive(1023, 1023, 1'b1, 1'b1);
    drain();

    // Asynchronous reset mid-accumulation with two samples in flight
    drive(5, 3, 1'b1, 1'b1);
    drive(5, 3, 1'b1, 1'b0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'({out_valid, p, pat_det, patb_det, pat_det_past, ones_o,
                                      overflow, ovf_sticky}), 32'd0);
    sb_q.delete();
    n_push = n_push - 2;
    m_acc = 24'd0;
    m_prev_pat = 1'b0;
    m_sticky = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    drive(5, 3, 1'b1, 1'b0);
    drain();

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    check("output_count", 32'(n_out), 32'(n_push));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
